// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, types and helpers for the pipeline stall/flush controller
package pipe_ctrl_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int STALL_W        = 6;

    // Stage indices into the stall vector
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef logic [DEF_REG_ADDR_W-1:0] reg_addr_bus_t;
    typedef logic [DEF_XLEN-1:0]       mem_addr_bus_t;
    typedef logic [STALL_W-1:0]        stall_vec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Freeze every stage from PC up to and including stg; later stages keep flowing,
    // so the register just past stg receives a bubble.
    function automatic stall_vec_t freeze_through(input int stg);
        stall_vec_t v;
        v = '0;
        for (int i = 0; i < STALL_W; i++) begin
            v[i] = (i <= stg);
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - core-side request/hazard inputs and stall/redirect outputs of pipe_ctrl
//
// master : pipeline side (drives requests and ID/EX info, consumes stall/redirect)
// slave  : pipe_ctrl side
// Signals: req_if/req_id/req_ex/req_mem stall requests; id_* decode info for the
// load-use check; ex_br_taken/ex_br_addr branch resolution; stall, discard,
// pc_redirect, pc_target, if_kill controller outputs.
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) ();

    logic                  req_if;
    logic                  req_id;
    logic                  req_ex;
    logic                  req_mem;
    logic                  id_is_load;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  ex_br_taken;
    logic [XLEN-1:0]       ex_br_addr;
    logic [STALL_W-1:0]    stall;
    logic                  discard;
    logic                  pc_redirect;
    logic [XLEN-1:0]       pc_target;
    logic                  if_kill;

    modport master (
        output req_if, req_id, req_ex, req_mem,
        output id_is_load, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_br_taken, ex_br_addr,
        input  stall, discard, pc_redirect, pc_target, if_kill
    );

    modport slave (
        input  req_if, req_id, req_ex, req_mem,
        input  id_is_load, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_br_taken, ex_br_addr,
        output stall, discard, pc_redirect, pc_target, if_kill
    );

endinterface

// File: rtl/pipe_ctrl_hazard.sv
// rtl/pipe_ctrl_hazard.sv - load-use hazard detector shadowing the ID/EX register
//
// Ports: clock, reset (sync, active-high); stall_id/stall_ex = stall[2]/stall[3];
// discard flush; id_is_load/id_rd/id_rs1/id_rs2/id_use_rs1/id_use_rs2 from ID;
// hz = ID reads a register the load now in EX has not yet produced.
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall_id,
    input  logic                  stall_ex,
    input  logic                  discard,
    input  logic                  id_is_load,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    output logic                  hz
);

    logic                  ex_load_v;
    logic [REG_ADDR_W-1:0] ex_load_rd;

    // Follows what the ID/EX register does: bubble/flush clears, advance captures, else hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_load_v  <= 1'b0;
            ex_load_rd <= '0;
        end else if (discard || (stall_id && !stall_ex)) begin
            ex_load_v  <= 1'b0;
        end else if (!stall_id && !stall_ex) begin
            ex_load_v  <= id_is_load;
            ex_load_rd <= id_rd;
        end
    end

    // x0 never carries a real dependency
    assign hz = ex_load_v && (ex_load_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_load_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_load_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush generator and branch-redirect sequencer for the 5-stage core
//
// Ports: clock, reset (sync, active-high); bus (pipe_ctrl_if.slave) carrying the
// stall requests, ID/EX hazard info, branch resolution and the stall/discard/
// pc_redirect/pc_target/if_kill outputs.
// Optional macro PIPE_CTRL_PERF_EN adds perf_stall_cycles, perf_hz_cycles and
// perf_flushes (32-bit wrapping counters, cleared by reset).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic        clock,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_hz_cycles,
    output logic [31:0] perf_flushes
`endif
);

    state_t             state;
    state_t             next_state;
    logic [XLEN-1:0]    pend_addr;
    logic               post_reset;
    logic               out_en;
    logic               hz;
    logic               acc;
    stall_vec_t         stall_raw;
    stall_vec_t         stall;
    logic               discard;
    logic               pc_redirect;
    logic [XLEN-1:0]    pc_target;
    logic               if_kill;

    // Outputs stay quiet for the reset cycle and the one after it.
    always_ff @(posedge clock) begin
        post_reset <= reset;
    end

    assign out_en = !reset && !post_reset;

    // A branch is only taken up while EX is free to move (stall[3] low) and no redirect is pending.
    assign acc = out_en && (state == ST_IDLE) && bus.ex_br_taken &&
                 !bus.req_mem && !bus.req_ex;

    pipe_ctrl_hazard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .clock      (clock),
        .reset      (reset),
        .stall_id   (stall[STG_ID]),
        .stall_ex   (stall[STG_EX]),
        .discard    (discard),
        .id_is_load (bus.id_is_load),
        .id_rd      (bus.id_rd),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .id_use_rs1 (bus.id_use_rs1),
        .id_use_rs2 (bus.id_use_rs2),
        .hz         (hz)
    );

    // Stall priority; ID-level requests are dropped when that instruction is being flushed.
    always_comb begin
        stall_raw = '0;
        if (bus.req_mem) begin
            stall_raw = freeze_through(STG_MEM);
        end else if (bus.req_ex) begin
            stall_raw = freeze_through(STG_EX);
        end else if ((bus.req_id || hz) && !acc) begin
            stall_raw = freeze_through(STG_ID);
        end else if (bus.req_if) begin
            stall_raw = freeze_through(STG_IF);
        end
    end

    always_comb begin
        stall = out_en ? stall_raw : '0;
        stall[STG_WB] = 1'b0;
    end

    // Redirect FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            pend_addr <= '0;
        end else begin
            state <= next_state;
            if ((state == ST_IDLE) && (next_state == ST_WAIT)) begin
                pend_addr <= bus.ex_br_addr;
            end
        end
    end

    // Redirect FSM: next state. WAIT holds the target until the in-flight fetch
    // has returned and the PC is free to load it.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (acc && bus.req_if) next_state = ST_WAIT;
            ST_WAIT: if (!bus.req_if && !stall[STG_PC]) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Redirect FSM: outputs
    always_comb begin
        discard     = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        if_kill     = 1'b0;
        if (out_en) begin
            case (state)
                ST_IDLE: begin
                    if (acc) begin
                        discard     = 1'b1;
                        pc_redirect = 1'b1;
                        pc_target   = bus.ex_br_addr;
                    end
                end
                ST_WAIT: begin
                    discard     = 1'b1;
                    pc_redirect = 1'b1;
                    pc_target   = pend_addr;
                    if_kill     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall       = stall;
    assign bus.discard     = discard;
    assign bus.pc_redirect = pc_redirect;
    assign bus.pc_target   = pc_target;
    assign bus.if_kill     = if_kill;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_hz_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_hz_q    <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall[STG_PC]) perf_stall_q <= perf_stall_q + 32'd1;
            if (hz && !acc && out_en) perf_hz_q <= perf_hz_q + 32'd1;
            if (acc) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_hz_cycles    = perf_hz_q;
    assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl (vector table, corner sequences, random vs model)
module tb_pipe_ctrl;

    logic clock;
    logic reset;

    pipe_ctrl_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_hz_cycles;
    logic [31:0] perf_flushes;
`endif

    pipe_ctrl #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_hz_cycles    (perf_hz_cycles),
        .perf_flushes      (perf_flushes)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst, rif, rid, rex, rmem, ld;
        logic [4:0]  rd, rs1, rs2;
        logic        u1, u2, br;
        logic [31:0] ba;
        logic [5:0]  e_stall;
        logic        e_disc, e_redir;
        logic [31:0] e_tgt;
        logic        e_kill;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pipeline seen as "how many stages are frozen" plus a pending-redirect flag.
    bit          m_post;
    bit          m_pending;
    logic [31:0] m_pend;
    bit          m_lv;
    logic [4:0]  m_lrd;
    int unsigned m_cnt_stall, m_cnt_hz, m_cnt_flush;

    function automatic vec_t mk(
        input logic rst, rif, rid, rex, rmem, ld,
        input logic [4:0] rd, rs1, input logic u1, input logic [4:0] rs2, input logic u2,
        input logic br, input logic [31:0] ba,
        input logic [5:0] es, input logic ed, er, input logic [31:0] et, input logic ek);
        vec_t v;
        v.rst = rst; v.rif = rif; v.rid = rid; v.rex = rex; v.rmem = rmem; v.ld = ld;
        v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.br = br; v.ba = ba;
        v.e_stall = es; v.e_disc = ed; v.e_redir = er; v.e_tgt = et; v.e_kill = ek;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset           = v.rst;
        bus.req_if      = v.rif;
        bus.req_id      = v.rid;
        bus.req_ex      = v.rex;
        bus.req_mem     = v.rmem;
        bus.id_is_load  = v.ld;
        bus.id_rd       = v.rd;
        bus.id_rs1      = v.rs1;
        bus.id_rs2      = v.rs2;
        bus.id_use_rs1  = v.u1;
        bus.id_use_rs2  = v.u2;
        bus.ex_br_taken = v.br;
        bus.ex_br_addr  = v.ba;
    endtask

    // One clock: drive after the edge, check mid-cycle, then advance the model.
    task automatic cycle(input vec_t v, input bit use_exp, input string tag);
        bit en, hz, acc, disc, redir, kill;
        int depth;
        logic [5:0]  st;
        logic [31:0] tgt;
        @(posedge clock);
        #1;
        apply(v);
        @(negedge clock);

        en  = !v.rst && !m_post;
        hz  = m_lv && (m_lrd != 0) && ((v.u1 && v.rs1 == m_lrd) || (v.u2 && v.rs2 == m_lrd));
        acc = en && !m_pending && v.br && !v.rmem && !v.rex;
        if (!en)                     depth = 0;
        else if (v.rmem)             depth = 5;
        else if (v.rex)              depth = 4;
        else if ((v.rid || hz) && !acc) depth = 3;
        else if (v.rif)              depth = 2;
        else                         depth = 0;
        st = 6'((1 << depth) - 1);
        disc = 0; redir = 0; kill = 0; tgt = 0;
        if (en && m_pending) begin
            disc = 1; redir = 1; kill = 1; tgt = m_pend;
        end else if (acc) begin
            disc = 1; redir = 1; tgt = v.ba;
        end

        chk({tag, " stall(model)"},   32'(bus.stall),       32'(st));
        chk({tag, " discard(model)"}, 32'(bus.discard),     32'(disc));
        chk({tag, " redir(model)"},   32'(bus.pc_redirect), 32'(redir));
        chk({tag, " target(model)"},  bus.pc_target,        tgt);
        chk({tag, " kill(model)"},    32'(bus.if_kill),     32'(kill));
        if (use_exp) begin
            chk({tag, " stall"},   32'(bus.stall),       32'(v.e_stall));
            chk({tag, " discard"}, 32'(bus.discard),     32'(v.e_disc));
            chk({tag, " redir"},   32'(bus.pc_redirect), 32'(v.e_redir));
            chk({tag, " target"},  bus.pc_target,        v.e_tgt);
            chk({tag, " kill"},    32'(bus.if_kill),     32'(v.e_kill));
        end

        // Next state as seen after the coming edge
        if (v.rst) begin
            m_pending = 0; m_pend = 0; m_lv = 0; m_lrd = 0;
            m_cnt_stall = 0; m_cnt_hz = 0; m_cnt_flush = 0;
        end else begin
            if (st[0]) m_cnt_stall++;
            if (hz && !acc && en) m_cnt_hz++;
            if (acc) m_cnt_flush++;
            // ID/EX register: flush or bubble empties it, advance loads ID, otherwise it holds
            if (disc || (st[2] && !st[3])) m_lv = 0;
            else if (!st[2] && !st[3]) begin m_lv = v.ld; m_lrd = v.rd; end
            if (m_pending) begin
                if (!v.rif && !st[0]) m_pending = 0;
            end else if (acc && v.rif) begin
                m_pending = 1; m_pend = v.ba;
            end
        end
        m_post = v.rst;
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        m_post = 1; m_pending = 0; m_pend = 0; m_lv = 0; m_lrd = 0;
        m_cnt_stall = 0; m_cnt_hz = 0; m_cnt_flush = 0;
        apply(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0));

        //              rst if id ex mem ld  rd rs1 u1 rs2 u2 br addr       stall     d r target     k
        tbl.push_back(mk(1, 0,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 1,0,0,0, 0,  0, 0, 0, 0, 0, 1, 32'h55,     6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 1,  5, 0, 0, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 5, 1, 0, 0, 0, 32'h0,      6'b000111,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 5, 1, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 1,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 1, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0,0,0,1, 0, 0, 0, 0, 0, 0, 1, 32'h100,  6'b011111,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 0, 0, 0, 1, 32'h100,    6'b000000,1,1,32'h100,   0));
        tbl.push_back(mk(0, 1,0,0,0, 0,  0, 0, 0, 0, 0, 1, 32'h2000,   6'b000011,1,1,32'h2000,  0));
        tbl.push_back(mk(0, 1,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000011,1,1,32'h2000,  1));
        tbl.push_back(mk(0, 1,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000011,1,1,32'h2000,  1));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000000,1,1,32'h2000,  1));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 1,  7, 0, 0, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 0, 7, 1, 1, 32'h300,    6'b000000,1,1,32'h300,   0));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 0, 7, 1, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 1,0,0,0, 0,  0, 0, 0, 0, 0, 1, 32'h400,    6'b000011,1,1,32'h400,   0));
        tbl.push_back(mk(1, 1,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 1,0,0,0, 0,  0, 0, 0, 0, 0, 1, 32'h500,    6'b000011,1,1,32'h500,   0));
        tbl.push_back(mk(0, 1,0,0,1, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b011111,1,1,32'h500,   1));
        tbl.push_back(mk(0, 0,0,0,1, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b011111,1,1,32'h500,   1));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000000,1,1,32'h500,   1));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,1,0, 0,  0, 0, 0, 0, 0, 1, 32'h600,    6'b001111,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,1,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000111,0,0,32'h0,     0));
        tbl.push_back(mk(0, 1,1,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000111,0,0,32'h0,     0));
        tbl.push_back(mk(0, 1,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000011,0,0,32'h0,     0));
        tbl.push_back(mk(0, 0,0,0,0, 0,  0, 0, 0, 0, 0, 0, 32'h0,      6'b000000,0,0,32'h0,     0));

        foreach (tbl[i]) cycle(tbl[i], 1'b1, $sformatf("row%0d", i));

        for (int i = 0; i < 600; i++) begin
            rv = mk($urandom_range(59) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
                    $urandom_range(7) == 0, $urandom_range(7) == 0, 1'($urandom_range(1)),
                    5'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom_range(1)),
                    5'($urandom_range(7)), 1'($urandom_range(1)),
                    $urandom_range(3) == 0, $urandom, 6'b0, 0, 0, 32'h0, 0);
            cycle(rv, 1'b0, $sformatf("rnd%0d", i));
        end

`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall vs model", perf_stall_cycles, m_cnt_stall);
        chk("perf_hz vs model",    perf_hz_cycles,    m_cnt_hz);
        chk("perf_flush vs model", perf_flushes,      m_cnt_flush);

        cycle(mk(1,0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0), 1'b0, "pf_rst");
        cycle(mk(0,0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0), 1'b0, "pf_post");
        for (int i = 0; i < 5; i++)
            cycle(mk(0,1,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0), 1'b0, "pf_stall");
        for (int i = 0; i < 2; i++)
            cycle(mk(0,0,0,0,0,0, 0,0,0,0,0, 1,32'h40, 0,0,0,0,0), 1'b0, "pf_flush");
        cycle(mk(0,0,0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0,0), 1'b0, "pf_idle");
        chk("perf_stall_cycles=5", perf_stall_cycles, 32'd5);
        chk("perf_flushes=2",      perf_flushes,      32'd2);
        chk("perf_hz_cycles=0",    perf_hz_cycles,    32'd0);

        @(posedge clock);
        #1;
        force dut.perf_stall_q = 32'hFFFF_FFFF;
        bus.req_if = 1'b1;
        @(negedge clock);
        release dut.perf_stall_q;
        @(negedge clock);
        chk("perf_stall wrap", perf_stall_cycles, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
